ahb2apb_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge.
- Sits directly upstream of the timer and the other APB peripherals, behind the AHB interconnect.
- Turns each single 32-bit AHB transfer into one APB SETUP/ACCESS sequence.
- Holds the AHB bus with HREADYOUT low until the APB side completes, then returns read data and the response.

---
 rtl/ahb2apb_bridge_if.sv | 40 ++++
 rtl/ahb2apb_bridge.sv | 130 +++++++++++++
 tb/tb_ahb2apb_bridge.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB bridge: AHB slave side plus APB master side.
// The slave modport is the bridge view; the master modport is the surrounding system.
interface ahb2apb_bridge_if #(
  parameter int unsigned HADDR_WIDTH    = 32,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH     = 32
);
  logic                      HSEL;
  logic [HADDR_WIDTH-1:0]    HADDR;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [DATA_WIDTH-1:0]     HWDATA;
  logic                      HREADY;
  logic                      HREADYOUT;
  logic                      HRESP;
  logic [DATA_WIDTH-1:0]     HRDATA;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS sequence per accepted single transfer.
// Optional ACCESS wait timeout is compiled in when APB_BRIDGE_TIMEOUT_EN is defined.
module ahb2apb_bridge #(
  parameter int unsigned HADDR_WIDTH    = 32,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb2apb_bridge_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERR1    = 3'd4;
  localparam logic [2:0] S_ERR2    = 3'd5;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  logic [2:0] state, state_nxt;
  logic       accept_c, bad_c, timeout_c;
  logic       psel_nxt, penable_nxt, hreadyout_nxt, hresp_nxt;
  logic       unused_bits;

  assign accept_c    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign bad_c       = (bus.HSIZE != SIZE_WORD) | (bus.HADDR[1:0] != 2'b00);
  assign unused_bits = ^{bus.HADDR[HADDR_WIDTH-1:APB_ADDR_WIDTH], bus.HTRANS[0]};

`ifdef APB_BRIDGE_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_c = !bus.PREADY && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Counts ACCESS cycles without PREADY; zeroed in SETUP so each access starts fresh.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wait_cnt <= 8'd0;
    end else if (state == S_SETUP) begin
      wait_cnt <= 8'd0;
    end else if ((state == S_ACCESS) && !bus.PREADY) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // Next state and next registered bus outputs.
  always_comb begin
    state_nxt     = state;
    psel_nxt      = 1'b0;
    penable_nxt   = 1'b0;
    hreadyout_nxt = 1'b1;
    hresp_nxt     = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept_c) begin
          state_nxt = bad_c ? S_ERR1 : S_SETUP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) begin
          state_nxt = bus.PSLVERR ? S_ERR1 : S_DONE;
        end else if (timeout_c) begin
          state_nxt = S_ERR1;
        end
      end
      S_ERR1:   state_nxt = S_ERR2;
      default:  state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_SETUP: begin
        psel_nxt      = 1'b1;
        hreadyout_nxt = 1'b0;
      end
      S_ACCESS: begin
        psel_nxt      = 1'b1;
        penable_nxt   = 1'b1;
        hreadyout_nxt = 1'b0;
      end
      S_ERR1: begin
        hreadyout_nxt = 1'b0;
        hresp_nxt     = 1'b1;
      end
      S_ERR2:  hresp_nxt = 1'b1;
      default: ;
    endcase
  end

  // State and all bus outputs are flops, so reset clears them without waiting for a clock.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state         <= S_IDLE;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
      bus.HRDATA    <= '0;
    end else begin
      state         <= state_nxt;
      bus.PSEL      <= psel_nxt;
      bus.PENABLE   <= penable_nxt;
      bus.HREADYOUT <= hreadyout_nxt;
      bus.HRESP     <= hresp_nxt;
      if (state_nxt == S_SETUP) begin
        bus.PADDR  <= bus.HADDR[APB_ADDR_WIDTH-1:0];
        bus.PWRITE <= bus.HWRITE;
      end
      // HWDATA is only valid in the AHB data phase, which is the SETUP cycle.
      if (state == S_SETUP) begin
        bus.PWDATA <= bus.HWDATA;
      end
      if ((state == S_ACCESS) && bus.PREADY && !bus.PSLVERR && !bus.PWRITE) begin
        bus.HRDATA <= bus.PRDATA;
      end
    end
  end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: directed and randomized single transfers against
// a transaction-level model (wait-state counts, response, data) derived from the bridge rules.
module tb_ahb2apb_bridge;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic HCLK;
  logic HRESET;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   setup_cyc = 0;
  int   done_cyc  = 0;
  logic [31:0] exp_hrdata = 32'h0;

  ahb2apb_bridge_if #(.HADDR_WIDTH(32), .APB_ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  ahb2apb_bridge #(
    .HADDR_WIDTH(32), .APB_ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  // Single-slave system: the bus-wide ready is the bridge's own ready.
  assign bus.HREADY = bus.HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.HSEL    = 1'b0;
    bus.HTRANS  = 2'b00;
    bus.HADDR   = 32'h0;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'b010;
    bus.HWDATA  = 32'h0;
    bus.PRDATA  = 32'h0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
  endtask

  // Drives one transfer starting in the current cycle and plays an APB slave that
  // asserts PREADY after 'waits' ACCESS cycles. Returns in the completion cycle.
  task automatic run_xfer(input string name, input logic [31:0] addr, input logic wr,
                          input logic [2:0] size, input logic [31:0] wdata, input int waits,
                          input logic slverr, input logic [31:0] rdata);
    logic        bad, tmo, err, psel_seen, last_resp, got_pwrite;
    logic [11:0] got_paddr;
    logic [31:0] got_pwdata;
    int          exp_low, exp_acc, low, acc;
    bad = (size != 3'b010) || (addr[1:0] != 2'b00);
`ifdef APB_BRIDGE_TIMEOUT_EN
    tmo = !bad && (waits >= int'(TIMEOUT_CYCLES));
`else
    tmo = 1'b0;
`endif
    err = bad || tmo || slverr;
    if (bad) begin
      exp_low = 1; exp_acc = 0;
    end else if (tmo) begin
      exp_acc = int'(TIMEOUT_CYCLES); exp_low = int'(TIMEOUT_CYCLES) + 2;
    end else begin
      exp_acc = waits + 1; exp_low = waits + 2 + (slverr ? 1 : 0);
    end
    got_paddr = 'x; got_pwrite = 1'bx; got_pwdata = 'x;

    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr; bus.HSIZE = size;
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wdata;
    bus.HADDR = $urandom; bus.HWRITE = ~wr; bus.HSIZE = 3'($urandom);

    low = 0; acc = 0; psel_seen = 1'b0; last_resp = 1'b0;
    while (bus.HREADYOUT !== 1'b1 && low < 64) begin
      low++;
      if (bus.PSEL === 1'b1 && !psel_seen) begin
        psel_seen = 1'b1;
        setup_cyc = cyc;
      end
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
        got_paddr   = bus.PADDR;
        got_pwrite  = bus.PWRITE;
        got_pwdata  = bus.PWDATA;
        bus.PREADY  = (acc == waits);
        bus.PSLVERR = (acc == waits) && slverr;
        bus.PRDATA  = (acc == waits) ? rdata : $urandom;
        acc++;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
      end
      last_resp = bus.HRESP;
      step();
    end
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    done_cyc = cyc;
    if (!err && !wr) exp_hrdata = rdata;

    n_tests++;
    if (low != exp_low) begin
      n_fail++; $display("FAIL %s wait_cycles got %0d exp %0d", name, low, exp_low);
    end
    n_tests++;
    if (acc != exp_acc) begin
      n_fail++; $display("FAIL %s access_cycles got %0d exp %0d", name, acc, exp_acc);
    end
    n_tests++;
    if (last_resp !== err) begin
      n_fail++; $display("FAIL %s hresp_last_wait got %b exp %b", name, last_resp, err);
    end
    n_tests++;
    if (bus.HRESP !== err) begin
      n_fail++; $display("FAIL %s hresp_final got %b exp %b", name, bus.HRESP, err);
    end
    n_tests++;
    if (bus.HRDATA !== exp_hrdata) begin
      n_fail++; $display("FAIL %s hrdata got %h exp %h", name, bus.HRDATA, exp_hrdata);
    end
    if (bad) begin
      n_tests++;
      if (psel_seen) begin
        n_fail++; $display("FAIL %s psel_on_bad got 1 exp 0", name);
      end
    end else begin
      n_tests++;
      if (got_paddr !== addr[11:0]) begin
        n_fail++; $display("FAIL %s paddr got %h exp %h", name, got_paddr, addr[11:0]);
      end
      n_tests++;
      if (got_pwrite !== wr) begin
        n_fail++; $display("FAIL %s pwrite got %b exp %b", name, got_pwrite, wr);
      end
      if (wr) begin
        n_tests++;
        if (got_pwdata !== wdata) begin
          n_fail++; $display("FAIL %s pwdata got %h exp %h", name, got_pwdata, wdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    idle_bus();
    step(); step();
    n_tests++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.HREADYOUT, bus.HRESP} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 00010",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.HREADYOUT, bus.HRESP});
    end
    n_tests++;
    if (bus.PADDR !== 12'h0) begin
      n_fail++; $display("FAIL reset_paddr got %h exp 000", bus.PADDR);
    end
    n_tests++;
    if (bus.PWDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_pwdata got %h exp 0", bus.PWDATA);
    end
    n_tests++;
    if (bus.HRDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_hrdata got %h exp 0", bus.HRDATA);
    end
    HRESET = 1'b0;
    exp_hrdata = 32'h0;
    step();
  endtask

  task automatic test_write();
    run_xfer("write_zero_wait", 32'h4000_0004, 1'b1, 3'b010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    step();
  endtask

  task automatic test_read_wait();
    run_xfer("read_3_waits", 32'h4000_0200, 1'b0, 3'b010, 32'h0, 3, 1'b0, 32'h0000_0001);
    step();
  endtask

  task automatic test_slverr();
    run_xfer("slverr_write", 32'h4000_0010, 1'b1, 3'b010, 32'h1234_5678, 0, 1'b1, 32'h0);
    run_xfer("after_slverr_read", 32'h4000_0014, 1'b0, 3'b010, 32'h0, 1, 1'b0, 32'hCAFE_F00D);
    step();
    run_xfer("slverr_read", 32'h4000_0018, 1'b0, 3'b010, 32'h0, 2, 1'b1, 32'h5555_AAAA);
    step();
  endtask

  task automatic test_bad();
    run_xfer("byte_write", 32'h4000_0020, 1'b1, 3'b000, 32'h0000_00AA, 0, 1'b0, 32'h0);
    step();
    run_xfer("misaligned_read", 32'h4000_0002, 1'b0, 3'b010, 32'h0, 0, 1'b0, 32'h9999_9999);
    run_xfer("after_bad_read", 32'h4000_0024, 1'b0, 3'b010, 32'h0, 0, 1'b0, 32'h0BAD_CAFE);
    step();
  endtask

  task automatic test_back_to_back();
    int first_done;
    run_xfer("b2b_first", 32'h0000_0000, 1'b1, 3'b010, 32'h1111_1111, 0, 1'b0, 32'h0);
    first_done = done_cyc;
    run_xfer("b2b_second", 32'h0000_0008, 1'b1, 3'b010, 32'h2222_2222, 0, 1'b0, 32'h0);
    n_tests++;
    if (setup_cyc != first_done + 1) begin
      n_fail++; $display("FAIL b2b_setup_cycle got %0d exp %0d", setup_cyc, first_done + 1);
    end
    step();
  endtask

  task automatic test_idle_busy();
    logic [1:0] ttype;
    for (int i = 0; i < 2; i++) begin
      ttype = 2'(i);
      bus.HSEL = 1'b1; bus.HTRANS = ttype; bus.HADDR = 32'h4000_0030; bus.HWRITE = 1'b1;
      step();
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
      n_tests++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b100) begin
        n_fail++;
        $display("FAIL idle_busy_%0d got %b exp 100", i, {bus.HREADYOUT, bus.HRESP, bus.PSEL});
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4000_0040; bus.HWRITE = 1'b1;
    bus.HSIZE = 3'b010;
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h7777_7777;
    bus.PREADY = 1'b0;
    step();
    n_tests++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
      n_fail++;
      $display("FAIL areset_pre_access got %b exp 110", {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
    end
    #3;
    HRESET = 1'b1;
    #1;
    n_tests++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 4'b0010) begin
      n_fail++;
      $display("FAIL areset_immediate got %b exp 0010",
               {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP});
    end
    step();
    HRESET = 1'b0;
    exp_hrdata = 32'h0;
    step();
    run_xfer("after_areset_read", 32'h4000_0044, 1'b0, 3'b010, 32'h0, 0, 1'b0, 32'h4444_0044);
    step();
  endtask

  task automatic test_timeout();
`ifdef APB_BRIDGE_TIMEOUT_EN
    run_xfer("timeout_read", 32'h4000_0050, 1'b0, 3'b010, 32'h0, 100, 1'b0, 32'hFFFF_0000);
    step();
    bus.PREADY = 1'b1; bus.PRDATA = 32'h1357_9BDF;
    step();
    bus.PREADY = 1'b0;
    n_tests++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b100 || bus.HRDATA !== exp_hrdata) begin
      n_fail++;
      $display("FAIL late_pready got %b/%h exp 100/%h", {bus.HREADYOUT, bus.HRESP, bus.PSEL},
               bus.HRDATA, exp_hrdata);
    end
    run_xfer("after_timeout_write", 32'h4000_0054, 1'b1, 3'b010, 32'hA5A5_5A5A, 0, 1'b0, 32'h0);
`else
    run_xfer("long_wait_read", 32'h4000_0050, 1'b0, 3'b010, 32'h0, 40, 1'b0, 32'hFFFF_0000);
`endif
    step();
  endtask

  task automatic test_random();
    logic [31:0] addr, data;
    logic [2:0]  size;
    logic        wr, serr;
    int          waits, gap;
    for (int i = 0; i < 40; i++) begin
      addr  = $urandom;
      if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'b010;
      wr    = 1'($urandom);
      data  = $urandom;
      waits = $urandom_range(0, 3);
      serr  = ($urandom_range(0, 7) == 0);
      gap   = $urandom_range(0, 2);
      run_xfer($sformatf("rand_%0d", i), addr, wr, size, data, waits, serr, data ^ 32'h5A5A_0F0F);
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  initial begin
    HRESET = 1'b1;
    idle_bus();
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_bad();
    test_back_to_back();
    test_idle_busy();
    test_async_reset();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
